// File: rtl/vga_sync_porch_pkg.sv
// Shared VGA 640x480 timing constants, lock-FSM state encoding and a window helper.
// Used by vga_sync_porch and vga_pos_counter.
package vga_sync_porch_pkg;

    localparam int CNT_W = 10;

    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_pos_counter.sv
// Column/row position counter with wrap and synchronous load to (0,0).
// Load has priority over advance; counters hold when neither is asserted.
module vga_pos_counter
    import vga_sync_porch_pkg::*;
#(
    parameter int TOTAL_COLS = H_TOTAL,
    parameter int TOTAL_ROWS = V_TOTAL
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             advance,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

    always_ff @(posedge clock) begin
        if (!reset_n || load) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_sync_porch.sv
// Regenerates active-low VGA syncs with porches, blanks and delays video by two clocks.
// Define VGA_SYNC_PORCH_CHECK_EN to enable frame_err reporting and ihsync consistency checks.
module vga_sync_porch
    import vga_sync_porch_pkg::*;
#(
    parameter int VIDEO_WIDTH   = 3,
    parameter int TOTAL_COLS    = H_TOTAL,
    parameter int TOTAL_ROWS    = V_TOTAL,
    parameter int ACTIVE_COLS   = H_ACTIVE,
    parameter int ACTIVE_ROWS   = V_ACTIVE,
    parameter int FRONT_PORCH_H = H_FRONT,
    parameter int SYNC_PULSE_H  = H_SYNC,
    parameter int FRONT_PORCH_V = V_FRONT,
    parameter int SYNC_PULSE_V  = V_SYNC
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   ihsync,
    input  logic                   ivsync,
    input  logic [VIDEO_WIDTH-1:0] ired,
    input  logic [VIDEO_WIDTH-1:0] igrn,
    input  logic [VIDEO_WIDTH-1:0] iblu,
    output logic                   ohsync,
    output logic                   ovsync,
    output logic [VIDEO_WIDTH-1:0] ored,
    output logic [VIDEO_WIDTH-1:0] ogrn,
    output logic [VIDEO_WIDTH-1:0] oblu,
    output logic                   locked,
    output logic                   frame_err
);

    localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(ACTIVE_COLS + FRONT_PORCH_H);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(ACTIVE_COLS + FRONT_PORCH_H + SYNC_PULSE_H);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(ACTIVE_ROWS + FRONT_PORCH_V);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(ACTIVE_ROWS + FRONT_PORCH_V + SYNC_PULSE_V);

    logic                   state_q;
    logic                   prev_vsync;
    logic                   fs;
    logic                   active;
    logic [CNT_W-1:0]       col;
    logic [CNT_W-1:0]       row;
    logic [VIDEO_WIDTH-1:0] red_q;
    logic [VIDEO_WIDTH-1:0] grn_q;
    logic [VIDEO_WIDTH-1:0] blu_q;

    assign fs     = ivsync & ihsync & ~prev_vsync;
    assign active = (col < ACT_COLS) && (row < ACT_ROWS);

    // Input history keeps tracking through reset so that a reset taken mid-frame
    // cannot mistake the ongoing active rows for a fresh frame start.
    always_ff @(posedge clock) begin
        prev_vsync <= ivsync;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_UNLOCKED;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
        end else begin
            red_q <= ired;
            grn_q <= igrn;
            blu_q <= iblu;
            if (fs) begin
                state_q <= ST_LOCKED;
            end
        end
    end

    vga_pos_counter #(
        .TOTAL_COLS(TOTAL_COLS),
        .TOTAL_ROWS(TOTAL_ROWS)
    ) u_pos (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (fs),
        .advance(state_q == ST_LOCKED),
        .col    (col),
        .row    (row)
    );

    always_ff @(posedge clock) begin
        if (!reset_n || state_q != ST_LOCKED) begin
            ohsync <= 1'b1;
            ovsync <= 1'b1;
            ored   <= '0;
            ogrn   <= '0;
            oblu   <= '0;
            locked <= 1'b0;
        end else begin
            ohsync <= ~in_window(col, HS_START, HS_END);
            ovsync <= ~in_window(row, VS_START, VS_END);
            ored   <= active ? red_q : '0;
            ogrn   <= active ? grn_q : '0;
            oblu   <= active ? blu_q : '0;
            locked <= 1'b1;
        end
    end

`ifdef VGA_SYNC_PORCH_CHECK_EN
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

    logic             err_q;
    logic             realign_err;
    logic             hsync_err;
    logic [CNT_W-1:0] sample_col;

    // Column the incoming sample will occupy once captured into stage 1.
    assign sample_col  = (fs || col == COL_LAST) ? '0 : col + 1'b1;
    assign realign_err = fs && !((col == COL_LAST) && (row == ROW_LAST));
    assign hsync_err   = ihsync != (sample_col < ACT_COLS);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            err_q     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            err_q     <= (state_q == ST_LOCKED) && (realign_err || hsync_err);
            frame_err <= err_q;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_porch.sv
// Randomized bench for vga_sync_porch on reduced timing, checked every cycle against a
// linear-pixel-index reference model; honours VGA_SYNC_PORCH_CHECK_EN like the design.
module tb_vga_sync_porch;

    localparam int VW    = 3;
    localparam int TC    = 40;
    localparam int TR    = 30;
    localparam int AC    = 24;
    localparam int AR    = 20;
    localparam int FPH   = 4;
    localparam int SPH   = 6;
    localparam int FPV   = 3;
    localparam int SPV   = 2;
    localparam int FRAME = TC * TR;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ihsync = 1'b0;
    logic          ivsync = 1'b0;
    logic [VW-1:0] ired = '0;
    logic [VW-1:0] igrn = '0;
    logic [VW-1:0] iblu = '0;
    logic          ohsync;
    logic          ovsync;
    logic [VW-1:0] ored;
    logic [VW-1:0] ogrn;
    logic [VW-1:0] oblu;
    logic          locked;
    logic          frame_err;

    always #5 clock = ~clock;

    vga_sync_porch #(
        .VIDEO_WIDTH  (VW),
        .TOTAL_COLS   (TC),
        .TOTAL_ROWS   (TR),
        .ACTIVE_COLS  (AC),
        .ACTIVE_ROWS  (AR),
        .FRONT_PORCH_H(FPH),
        .SYNC_PULSE_H (SPH),
        .FRONT_PORCH_V(FPV),
        .SYNC_PULSE_V (SPV)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ihsync   (ihsync),
        .ivsync   (ivsync),
        .ired     (ired),
        .igrn     (igrn),
        .iblu     (iblu),
        .ohsync   (ohsync),
        .ovsync   (ovsync),
        .ored     (ored),
        .ogrn     (ogrn),
        .oblu     (oblu),
        .locked   (locked),
        .frame_err(frame_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Pattern source position and one-shot stimulus overrides
    int scol = 0;
    int srow = 0;
    bit glitch_h = 0;
    bit kill_v = 0;
    int video_mode = 0;

    // Reference model: stage-1 contents expressed as a linear pixel index
    bit          m_locked = 0;
    bit          m_prev_v = 0;
    bit          m_err = 0;
    int          m_idx = 0;
    logic [VW-1:0] m_r = '0;
    logic [VW-1:0] m_g = '0;
    logic [VW-1:0] m_b = '0;

    logic          e_hs;
    logic          e_vs;
    logic          e_locked;
    logic          e_err;
    logic [VW-1:0] e_r;
    logic [VW-1:0] e_g;
    logic [VW-1:0] e_b;

    int dut_err_pulses = 0;
    int exp_err_pulses = 0;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d src=(%0d,%0d) got=%0d expected=%0d",
                     tag, cyc, scol, srow, actual, expected);
        end
    endtask

    task automatic model_edge();
        int c;
        int r;
        int pred;
        int nxt;
        bit act;
        bit fs;
        if (!reset_n) begin
            e_hs = 1; e_vs = 1; e_locked = 0; e_err = 0;
            e_r = '0; e_g = '0; e_b = '0;
            m_locked = 0; m_idx = 0; m_err = 0;
            m_r = '0; m_g = '0; m_b = '0;
        end else begin
            if (m_locked) begin
                c = m_idx % TC;
                r = m_idx / TC;
                act = (c < AC) && (r < AR);
                e_r = act ? m_r : '0;
                e_g = act ? m_g : '0;
                e_b = act ? m_b : '0;
                e_hs = !(c >= AC + FPH && c < AC + FPH + SPH);
                e_vs = !(r >= AR + FPV && r < AR + FPV + SPV);
                e_locked = 1;
                e_err = m_err;
            end else begin
                e_hs = 1; e_vs = 1; e_locked = 0; e_err = 0;
                e_r = '0; e_g = '0; e_b = '0;
            end
            fs = ivsync && ihsync && !m_prev_v;
            m_r = ired; m_g = igrn; m_b = iblu;
            m_err = 0;
            if (!m_locked) begin
                m_idx = 0;
                if (fs) m_locked = 1;
            end else begin
                pred = (m_idx + 1) % FRAME;
                nxt = fs ? 0 : pred;
`ifdef VGA_SYNC_PORCH_CHECK_EN
                m_err = (fs && pred != 0) || (ihsync != ((nxt % TC) < AC));
`endif
                m_idx = nxt;
            end
        end
        m_prev_v = ivsync;
    endtask

    task automatic apply_stimulus(input bit rst_n);
        bit in_act;
        @(negedge clock);
        reset_n = rst_n;
        in_act = (scol < AC) && (srow < AR);
        ihsync = (scol < AC) ^ glitch_h;
        ivsync = (srow < AR) && !kill_v;
        case (video_mode)
            0: begin
                ired = in_act ? VW'(7) : VW'($urandom);
                igrn = in_act ? VW'(7) : VW'($urandom);
                iblu = in_act ? VW'(7) : VW'($urandom);
            end
            1: begin
                ired = VW'($urandom);
                igrn = VW'($urandom);
                iblu = VW'($urandom);
            end
            default: begin
                ired = VW'(5);
                igrn = VW'($urandom);
                iblu = VW'($urandom);
            end
        endcase
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        check_output("ohsync", 32'(ohsync), 32'(e_hs));
        check_output("ovsync", 32'(ovsync), 32'(e_vs));
        check_output("rgb", 32'({ored, ogrn, oblu}), 32'({e_r, e_g, e_b}));
        check_output("locked", 32'(locked), 32'(e_locked));
        check_output("frame_err", 32'(frame_err), 32'(e_err));
        if (frame_err === 1'b1) dut_err_pulses++;
        if (e_err) exp_err_pulses++;
        glitch_h = 0;
        kill_v = 0;
        scol++;
        if (scol == TC) begin
            scol = 0;
            srow = (srow + 1) % TR;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1);
    endtask

    // Advance until the next sample to be driven is at (row, col).
    task automatic run_until(input int row, input int col);
        int guard;
        guard = 0;
        while (!(srow == row && scol == col) && guard <= FRAME) begin
            apply_stimulus(1);
            guard++;
        end
        if (guard > FRAME) check_output("run_until_bound", 32'(guard), 32'(FRAME));
    endtask

    task automatic inject_fs();
        kill_v = 1;
        apply_stimulus(1);
        scol = 0;
        srow = 0;
    endtask

    initial begin
        int r;
        int c;
        int pulses_before;
        int exp_before;

        scol = int'($urandom_range(TC - 1, 0));
        srow = int'($urandom_range(TR - 1, 0));
        video_mode = 0;
        for (int i = 0; i < 5; i++) apply_stimulus(0);
        check_output("reset_locked", 32'(locked), 32'(0));
        check_output("reset_hsync", 32'(ohsync), 32'(1));

        $display("[TB] nominal frames");
        run_cycles(3 * FRAME);
        check_output("nominal_locked", 32'(locked), 32'(1));
        check_output("nominal_err_count", 32'(dut_err_pulses), 32'(0));

        $display("[TB] early frame start");
        video_mode = 1;
        r = int'($urandom_range(AR - 2, 2));
        run_until(r - 1, TC - 1);
        pulses_before = dut_err_pulses;
        exp_before = exp_err_pulses;
        inject_fs();
        run_cycles(FRAME + 50);
        check_output("early_fs_pulses", 32'(dut_err_pulses - pulses_before),
                     32'(exp_err_pulses - exp_before));

        $display("[TB] mid-frame reset");
        video_mode = 2;
        r = int'($urandom_range(AR - 1, 1));
        c = int'($urandom_range(AC - 1, 1));
        run_until(r, c);
        apply_stimulus(0);
        run_cycles(TC);
        check_output("reset_relock_wait", 32'(locked), 32'(0));
        run_cycles(2 * FRAME);
        check_output("reset_relocked", 32'(locked), 32'(1));

        $display("[TB] ihsync glitches");
        video_mode = 0;
        for (int k = 0; k < 3; k++) begin
            r = int'($urandom_range(AR - 1, 0));
            c = int'($urandom_range(AC - 1, 1));
            run_until(r, c);
            pulses_before = dut_err_pulses;
            exp_before = exp_err_pulses;
            glitch_h = 1;
            apply_stimulus(1);
            run_cycles(4);
            check_output("glitch_pulses", 32'(dut_err_pulses - pulses_before),
                         32'(exp_err_pulses - exp_before));
        end

        $display("[TB] random unexpected frame starts");
        video_mode = 1;
        for (int k = 0; k < 3; k++) begin
            run_cycles(int'($urandom_range(FRAME, 10)));
            inject_fs();
            run_cycles(FRAME / 2);
        end
        run_cycles(FRAME + 10);
        check_output("total_err_pulses", 32'(dut_err_pulses), 32'(exp_err_pulses));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_porch.md
Name: vga_sync_porch

Overview:
- Stage directly downstream of the test-pattern generator; the last block before the VGA pins.
- Consumes active-high "in active region" hsync/vsync plus RGB video, and regenerates standard active-low sync pulses with front/back porch.
- Delays video so it aligns with the regenerated syncs, and forces video to zero outside the active area.
- Maintains its own lock to the frame start; realigns on any unexpected frame start.

Parameters:
VIDEO_WIDTH, 3, bits per colour channel
TOTAL_COLS, 800, clocks per line
TOTAL_ROWS, 525, lines per frame
ACTIVE_COLS, 640, visible columns
ACTIVE_ROWS, 480, visible rows
FRONT_PORCH_H, 16, columns between active end and hsync pulse
SYNC_PULSE_H, 96, hsync pulse width in columns
FRONT_PORCH_V, 10, rows between active end and vsync pulse
SYNC_PULSE_V, 2, vsync pulse width in rows

Ports:
clock  input  1  pixel clock
reset_n  input  1  synchronous, active-low reset
ihsync  input  1  high during active columns
ivsync  input  1  high during active rows
ired  input  VIDEO_WIDTH  red video in
igrn  input  VIDEO_WIDTH  green video in
iblu  input  VIDEO_WIDTH  blue video in
ohsync  output  1  active-low hsync pulse
ovsync  output  1  active-low vsync pulse
ored  output  VIDEO_WIDTH  red out, blanked
ogrn  output  VIDEO_WIDTH  green out, blanked
oblu  output  VIDEO_WIDTH  blue out, blanked
locked  output  1  high once aligned to a frame start
frame_err  output  1  one-cycle pulse on unexpected frame start

Behaviour:
- Reset: one clock only; reset_n is synchronous and active-low, sampled on the rising edge of clock.
  - While reset_n=0: ohsync=1, ovsync=1, colour outputs=0, locked=0, frame_err=0, col/row counters=0, pipeline registers=0, FSM=UNLOCKED.
  - A reset mid-frame takes effect on the next edge. After release, the block relocks on the next frame start.
- Frame start (FS): a sample where ivsync=1 and ihsync=1, and the previous sample had ivsync=0. That sample is position col=0, row=0.
- Stage 1 (registered): capture video; track the col/row of the captured sample.
  - col increments each clock and wraps TOTAL_COLS-1 -> 0.
  - When col wraps, row increments and wraps TOTAL_ROWS-1 -> 0.
  - On FS, load col=0 and row=0 regardless of the current count.
  - Counters are 10 bits wide. Parameters must be < 1024; no other range checking is done.
- Stage 2 (registered outputs):
  - Active area is col<ACTIVE_COLS && row<ACTIVE_ROWS. In the active area, colour outputs = stage-1 video; otherwise 0.
  - ohsync=0 iff ACTIVE_COLS+FRONT_PORCH_H <= col < ACTIVE_COLS+FRONT_PORCH_H+SYNC_PULSE_H.
  - ovsync=0 iff ACTIVE_ROWS+FRONT_PORCH_V <= row < ACTIVE_ROWS+FRONT_PORCH_V+SYNC_PULSE_V.
  - Back porch is implicit: the remainder of the total after the pulse.
- Latency: input pin to every output is exactly 2 clocks.
- FSM:
  - UNLOCKED: outputs held idle (syncs 1, video 0) and counters frozen at 0. On FS -> LOCKED, and counters load (0,0).
  - LOCKED: free-running counters and normal outputs. locked=1 from the first stage-2 cycle of the aligned frame.
  - An FS arriving when the counter's predicted position of that sample is not (0,0) causes a realign to (0,0), a one-cycle frame_err pulse aligned with stage 2, and the FSM stays LOCKED.
  - An FS arriving exactly when the counter wraps to (0,0) causes no error.
- Input video while ihsync/ivsync are low is ignored, because it is blanked by the counter position.
- An FS coinciding with the first edge after reset release is honoured.

Optional Feature:
- Macro: VGA_SYNC_PORCH_CHECK_EN.
- Defined: frame_err is generated as above. Additionally, while LOCKED, the block checks ihsync against the expected col<ACTIVE_COLS. Any mismatch pulses frame_err for one cycle; no realign occurs.
- Undefined: no checking logic; frame_err is tied to 0; realign on an unexpected FS still occurs silently.

Decomposition:
- Shared package/header: VGA 640x480 timing constants (totals, actives, porches, pulses), plus FSM state encoding UNLOCKED=0, LOCKED=1.
- One natural sub-module: vga_pos_counter (col/row counter with wrap and synchronous load), reused by future timing stages.

Test Plan:
- Reset: hold reset_n=0 for 5 clocks while driving a pattern -> ohsync=ovsync=1, RGB=0, locked=0 throughout.
- Nominal frame: drive the pattern-generator timing (800x525, active 640x480, RGB=3'b111 when active) for 2 frames. Required response:
  - ohsync low for exactly 96 clocks starting at col 656 of each line.
  - ovsync low for rows 490-491.
  - RGB=7 exactly over the 640x480 area, 2-clock latency.
  - locked=1 and frame_err=0.
- Early frame start: after lock, inject FS at row 200, col 0 -> single frame_err pulse; counters realign; the next outputs match an FS-at-(0,0) reference.
- Mid-frame reset: assert reset_n=0 for 1 clock at row 100 -> idle outputs and locked=0 until the next FS; clean output from that frame on.
- Blanking: drive ired=5 continuously, including porches -> ored=0 whenever col>=640 or row>=480.
- Macro on: flip ihsync low for one clock at col 300 while locked -> one frame_err pulse; sync timing unchanged. Macro off: same stimulus -> frame_err stays 0.
